mips_hazard_unit: RTL and testbench
===================================

// Module: mips_hazard_unit
// PURPOSE
// - Control-side partner of the pipelined MIPS datapath. Consumes the IF/ID instruction
//   and drives the datapath's forwarding selects plus stall/bubble controls.
// - Tracks the instructions in EX and MEM in its own history registers, which makes it
//   the authoritative view of pipeline occupancy.
// - Detects RAW hazards:
//   - forwards from EX (ALU result) or MEM (Dw) into ID;
//   - stalls one cycle on load-use.
// PARAMETERS
// - STALL_CNT_W   32       width of the stall performance counter
// - NOP_INSTR     32'h0    encoding injected as a bubble (sll $0,$0,0)
// PORTS
// - clk            in   1   single clock, rising edge
// - rst            in   1   synchronous, active-high reset
// - if_id_instr    in   32  instruction currently in ID (IF/ID register output)
// - ex_forward_a   out  1   1: ID operand A takes ALU out of EX stage
// - ex_forward_b   out  1   1: ID operand B takes ALU out of EX stage
// - mem_forward_a  out  1   1: ID operand A takes Dw of MEM stage (ignored when ex_forward_a=1)
// - mem_forward_b  out  1   1: ID operand B takes Dw of MEM stage (ignored when ex_forward_b=1)
// - pc_stall       out  1   hold PC this cycle
// - if_id_stall    out  1   hold IF/ID register this cycle
// - id_ex_bubble   out  1   load NOP_INSTR controls into ID/EX this cycle
// - stall_count    out  STALL_CNT_W  count of load-use stall cycles since reset
// BEHAVIOUR
// - History registers `ex_instr` and `mem_instr`, updated on each rising clk:
//   - mem_instr <= ex_instr;
//   - ex_instr <= (stall ? NOP_INSTR : if_id_instr).
// - Destination decode, dst(i):
//   - R-type (op 0) -> rd;
//   - addi/addiu/andi/ori/slti/lui/lw -> rt;
//   - sw/beq/bne/j/jr -> none.
//   - A destination of $0 counts as none; $0 is never forwarded.
// - Source decode, ID instruction:
//   - R-type reads rs,rt; jr reads rs only;
//   - I-type ALU and lw read rs;
//   - sw/beq/bne read rs,rt;
//   - j reads none.
// - Forward selects are combinational from if_id_instr, ex_instr and mem_instr. They are
//   valid in the same cycle the ID operands are captured into ID/EX.
//   - ex_forward_a = rs used && dst(ex_instr)==rs && ex_instr not lw.
//   - mem_forward_a = rs used && dst(mem_instr)==rs. Forcing it to 0 when
//     ex_forward_a=1 is not required.
//   - B side: same rules with rt.
//   - EX has priority over MEM when both match.
// - Load-use hazard: ex_instr is lw && dst(ex_instr) matches a used source of the ID
//   instruction.
// - FSM states RUN and STALL:
//   - RUN -> STALL on load-use. While the hazard is asserted, pc_stall = if_id_stall =
//     id_ex_bubble = 1 and ex_forward_* are forced to 0.
//   - STALL -> RUN unconditionally after 1 cycle. The load is now in MEM and the held
//     instruction resolves via mem_forward_*.
//   - Back-to-back loads feeding each other stall once per dependent pair.
// - stall_count increments by 1 in each stall cycle and wraps at 2^STALL_CNT_W.
// - WB-stage hazards are out of scope; the regfile provides write-before-read.
// - Reset:
//   - ex_instr = mem_instr = NOP_INSTR, state RUN, stall_count 0;
//   - all forward/stall outputs 0 in the first cycle after reset.
//   - rst asserted in STALL aborts the stall; the next cycle is RUN with empty history.
// - Latency: forward and stall outputs are 0-cycle (combinational) relative to
//   if_id_instr. History updates take 1 cycle.
// STRUCTURE
// - Shared package mips_pkg:
//   - opcode constants OP_RTYPE=6'h00, OP_J=6'h02, OP_BEQ=6'h04, OP_BNE=6'h05,
//     OP_ADDI=6'h08, OP_ORI=6'h0D, OP_LW=6'h23, OP_SW=6'h2B, FUNCT_JR=6'h08;
//   - typedef enum logic {RUN, STALL} hz_state_t.
// - One sub-module `mips_instr_decode`: combinational, instr -> {dst[4:0], dst_vld,
//   rs_used, rt_used, is_load}. It is instantiated three times (ID, EX, MEM).
// TESTING
// 1. Reset 2 cycles with if_id_instr=0 -> all outputs 0, stall_count=0.
// 2. addi $1,$0,5 then add $2,$1,$1 -> with add in ID: ex_forward_a=ex_forward_b=1,
//    mem_forward_*=0, no stall.
// 3. addi $1,$0,5; nop; add $3,$1,$0 -> with add in ID: mem_forward_a=1, ex_forward_a=0,
//    mem_forward_b=0.
// 4. lw $4,0($0); add $5,$4,$0 ->
//    - one cycle with pc_stall=if_id_stall=id_ex_bubble=1, ex_forward_a=0;
//    - next cycle mem_forward_a=1;
//    - stall_count=1.
// 5. addi $1,$0,1; addi $1,$0,2; add $2,$1,$0 -> ex_forward_a=1 (EX priority). Also
//    addi $0,$0,7; add $2,$0,$0 -> no forward.
// 6. Scenario 4 with rst=1 during the stall cycle -> next cycle all outputs 0,
//    stall_count=0, FSM in RUN.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct encodings, decoded-instruction record and
// hazard-unit FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic {RUN, STALL} hz_state_t;

  typedef struct packed {
    logic [4:0] dst;
    logic       dst_vld;
    logic       rs_used;
    logic       rt_used;
    logic       is_load;
  } dec_t;

endpackage

// File: rtl/mips_instr_decode.sv
// Combinational register-usage decode of one instruction: destination register,
// which source fields are read, and whether it is a load.
module mips_instr_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_shamt;

  assign op           = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    // NOTE: every field gets a default first so no path through the case infers a latch.
    dec = '0;
    case (op)
      OP_RTYPE: begin
        if (funct == FUNCT_JR) begin
          dec.rs_used = 1'b1;
        end else begin
          dec.dst     = instr[15:11];
          dec.dst_vld = 1'b1;
          dec.rs_used = 1'b1;
          dec.rt_used = 1'b1;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        dec.dst     = instr[20:16];
        dec.dst_vld = 1'b1;
        dec.rs_used = 1'b1;
      end
      OP_LW: begin
        dec.dst     = instr[20:16];
        dec.dst_vld = 1'b1;
        dec.rs_used = 1'b1;
        dec.is_load = 1'b1;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        dec.rs_used = 1'b1;
        dec.rt_used = 1'b1;
      end
      OP_J: ;
      default: ;
    endcase
    // Writes to $0 are discarded by the regfile, so they never produce a value to forward.
    if (dec.dst == 5'd0) dec.dst_vld = 1'b0;
  end

endmodule

// File: rtl/mips_hazard_unit.sv
// Pipeline hazard unit: tracks EX/MEM instructions, drives ID forwarding selects and
// a one-cycle load-use stall with a stall performance counter.
module mips_hazard_unit
  import mips_pkg::*;
#(
  parameter int          STALL_CNT_W = 32,
  parameter logic [31:0] NOP_INSTR   = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            if_id_instr,
  output logic                   ex_forward_a,
  output logic                   ex_forward_b,
  output logic                   mem_forward_a,
  output logic                   mem_forward_b,
  output logic                   pc_stall,
  output logic                   if_id_stall,
  output logic                   id_ex_bubble,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic [31:0] ex_instr;
  logic [31:0] mem_instr;
  hz_state_t   state;
  dec_t        id_dec, ex_dec, mem_dec;
  logic [4:0]  id_rs, id_rt;
  logic        rs_hit_ex, rt_hit_ex, rs_hit_mem, rt_hit_mem;
  logic        load_use, stall_now;
  logic        unused_dec;

  mips_instr_decode u_dec_id  (.instr(if_id_instr), .dec(id_dec));
  mips_instr_decode u_dec_ex  (.instr(ex_instr),    .dec(ex_dec));
  mips_instr_decode u_dec_mem (.instr(mem_instr),   .dec(mem_dec));

  assign unused_dec = ^{id_dec.dst, id_dec.dst_vld, id_dec.is_load,
                        ex_dec.rs_used, ex_dec.rt_used,
                        mem_dec.rs_used, mem_dec.rt_used, mem_dec.is_load};

  assign id_rs = if_id_instr[25:21];
  assign id_rt = if_id_instr[20:16];

  assign rs_hit_ex  = id_dec.rs_used && ex_dec.dst_vld  && (ex_dec.dst  == id_rs);
  assign rt_hit_ex  = id_dec.rt_used && ex_dec.dst_vld  && (ex_dec.dst  == id_rt);
  assign rs_hit_mem = id_dec.rs_used && mem_dec.dst_vld && (mem_dec.dst == id_rs);
  assign rt_hit_mem = id_dec.rt_used && mem_dec.dst_vld && (mem_dec.dst == id_rt);

  // A load's data is not ready in EX; that case stalls instead of forwarding.
  assign load_use  = ex_dec.is_load && (rs_hit_ex || rt_hit_ex);
  assign stall_now = load_use && (state == RUN);

  assign ex_forward_a  = rs_hit_ex && !ex_dec.is_load && !stall_now;
  assign ex_forward_b  = rt_hit_ex && !ex_dec.is_load && !stall_now;
  assign mem_forward_a = rs_hit_mem;
  assign mem_forward_b = rt_hit_mem;
  assign pc_stall      = stall_now;
  assign if_id_stall   = stall_now;
  assign id_ex_bubble  = stall_now;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      ex_instr    <= NOP_INSTR;
      mem_instr   <= NOP_INSTR;
      state       <= RUN;
      stall_count <= '0;
    end else begin
      mem_instr <= ex_instr;
      ex_instr  <= stall_now ? NOP_INSTR : if_id_instr;
      if (stall_now) stall_count <= stall_count + STALL_CNT_W'(1);
      case (state)
        RUN:   if (load_use) state <= STALL;
        STALL: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_hazard_unit.sv
// Directed scoreboard bench for mips_hazard_unit: expectations are queued when an
// instruction is presented and compared mid-cycle against the combinational outputs.
module tb_mips_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_id_instr;
  logic        ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b;
  logic        pc_stall, if_id_stall, id_ex_bubble;
  logic [31:0] stall_count;

  typedef struct packed {
    logic        efa, efb, mfa, mfb, stl;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_asserts = 0;
  int   n_fails   = 0;

  always #5 clk = ~clk;

  mips_hazard_unit #(.STALL_CNT_W(32), .NOP_INSTR(32'h0)) dut (
    .clk(clk), .rst(rst), .if_id_instr(if_id_instr),
    .ex_forward_a(ex_forward_a), .ex_forward_b(ex_forward_b),
    .mem_forward_a(mem_forward_a), .mem_forward_b(mem_forward_b),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_bubble(id_ex_bubble),
    .stall_count(stall_count)
  );

  function automatic logic [31:0] r_add(input logic [4:0] rd, rs, rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rt, rs,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t mk(input logic efa, efb, mfa, mfb, stl, input int cnt);
    exp_t e;
    e.efa = efa; e.efb = efb; e.mfa = mfa; e.mfb = mfb; e.stl = stl; e.cnt = cnt;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present one instruction just after a rising edge and check it at the falling edge.
  task automatic step(input string tag, input logic [31:0] instr, input logic r, input exp_t e);
    exp_t got;
    @(posedge clk);
    #1;
    rst         = r;
    if_id_instr = instr;
    exp_q.push_back(e);
    @(negedge clk);
    got = exp_q.pop_front();
    check({tag, ".ex_fwd_a"},  32'(ex_forward_a),  32'(got.efa));
    check({tag, ".ex_fwd_b"},  32'(ex_forward_b),  32'(got.efb));
    check({tag, ".mem_fwd_a"}, 32'(mem_forward_a), 32'(got.mfa));
    check({tag, ".mem_fwd_b"}, 32'(mem_forward_b), 32'(got.mfb));
    check({tag, ".pc_stall"},  32'(pc_stall),      32'(got.stl));
    check({tag, ".ifid_stall"}, 32'(if_id_stall),  32'(got.stl));
    check({tag, ".bubble"},    32'(id_ex_bubble),  32'(got.stl));
    check({tag, ".count"},     stall_count,        got.cnt);
  endtask

  localparam logic [5:0] ADDI = 6'h08, LW = 6'h23, SW = 6'h2B;

  initial begin
    rst         = 1'b1;
    if_id_instr = 32'h0;
    @(posedge clk);
    step("reset",       32'h0, 1'b1, mk(0, 0, 0, 0, 0, 0));

    // EX forwarding on both operands
    step("s2_addi",     i_op(ADDI, 5'd1, 5'd0, 16'd5), 1'b0, mk(0, 0, 0, 0, 0, 0));
    step("s2_add",      r_add(5'd2, 5'd1, 5'd1),       1'b0, mk(1, 1, 0, 0, 0, 0));

    // MEM forwarding across a nop
    step("s3_addi",     i_op(ADDI, 5'd1, 5'd0, 16'd5), 1'b0, mk(0, 0, 0, 0, 0, 0));
    step("s3_nop",      32'h0,                         1'b0, mk(0, 0, 0, 0, 0, 0));
    step("s3_add",      r_add(5'd3, 5'd1, 5'd0),       1'b0, mk(0, 0, 1, 0, 0, 0));

    // Load-use on rs: one stall cycle, then MEM forward
    step("s4_lw",       i_op(LW, 5'd4, 5'd0, 16'd0),   1'b0, mk(0, 0, 0, 0, 0, 0));
    step("s4_stall",    r_add(5'd5, 5'd4, 5'd0),       1'b0, mk(0, 0, 0, 0, 1, 0));
    step("s4_resolve",  r_add(5'd5, 5'd4, 5'd0),       1'b0, mk(0, 0, 1, 0, 0, 1));

    // EX has priority; MEM select still reports its own match
    step("s5_addi1",    i_op(ADDI, 5'd1, 5'd0, 16'd1), 1'b0, mk(0, 0, 0, 0, 0, 1));
    step("s5_addi2",    i_op(ADDI, 5'd1, 5'd0, 16'd2), 1'b0, mk(0, 0, 0, 0, 0, 1));
    step("s5_add",      r_add(5'd2, 5'd1, 5'd0),       1'b0, mk(1, 0, 1, 0, 0, 1));
    step("s5_addi0",    i_op(ADDI, 5'd0, 5'd0, 16'd7), 1'b0, mk(0, 0, 0, 0, 0, 1));
    step("s5_zero",     r_add(5'd2, 5'd0, 5'd0),       1'b0, mk(0, 0, 0, 0, 0, 1));

    // Back-to-back dependent loads, then a store whose rt depends on the second load
    step("b2b_lw1",     i_op(LW, 5'd6, 5'd0, 16'd0),   1'b0, mk(0, 0, 0, 0, 0, 1));
    step("b2b_stall1",  i_op(LW, 5'd7, 5'd6, 16'd0),   1'b0, mk(0, 0, 0, 0, 1, 1));
    step("b2b_lw2",     i_op(LW, 5'd7, 5'd6, 16'd0),   1'b0, mk(0, 0, 1, 0, 0, 2));
    step("sw_stall",    i_op(SW, 5'd7, 5'd0, 16'd0),   1'b0, mk(0, 0, 0, 0, 1, 2));
    step("sw_resolve",  i_op(SW, 5'd7, 5'd0, 16'd0),   1'b0, mk(0, 0, 0, 1, 0, 3));
    step("sw_no_dst",   r_add(5'd8, 5'd7, 5'd0),       1'b0, mk(0, 0, 0, 0, 0, 3));

    // Reset asserted during the stall cycle aborts it
    step("s6_lw",       i_op(LW, 5'd4, 5'd0, 16'd0),   1'b0, mk(0, 0, 0, 0, 0, 3));
    step("s6_stall_rst", r_add(5'd5, 5'd4, 5'd0),      1'b1, mk(0, 0, 0, 0, 1, 3));
    step("s6_after",    r_add(5'd5, 5'd4, 5'd0),       1'b0, mk(0, 0, 0, 0, 0, 0));
    step("s6_run",      r_add(5'd9, 5'd5, 5'd4),       1'b0, mk(1, 0, 0, 0, 0, 0));

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
